// File: rtl/run_detect_pkg.sv
// Shared types and default sizing for the run detector.
// Holds the FSM state encoding and the run-counter width helper.
package run_detect_pkg;

    localparam int DEF_DATA_W  = 4;
    localparam int DEF_RUN_LEN = 4;
    localparam int DEF_CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEEK     = 2'd1,
        WAIT_LOW = 2'd2
    } state_t;

    // clog2 of the run length, never narrower than one bit
    function automatic int run_cnt_width(input int run_len);
        return (run_len <= 2) ? 1 : $clog2(run_len);
    endfunction

endpackage

// File: rtl/run_detect.sv
// Run detector: captures a threshold on command, then counts distinct runs of
// RUN_LEN consecutive samples strictly above it, with a saturating counter.
module run_detect
    import run_detect_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int RUN_LEN = DEF_RUN_LEN,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              strtCapCmp,
    input  logic [DATA_W-1:0] sig,
    output logic [CNT_W-1:0]  N_abv
);

    localparam int RC_W = run_cnt_width(RUN_LEN);
    localparam logic [RC_W-1:0]  RUN_LAST = RC_W'(RUN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t            state_r,   state_nx_s;
    logic [DATA_W-1:0] thresh_r,  thresh_nx_s;
    logic [RC_W-1:0]   run_cnt_r, run_cnt_nx_s;
    logic [CNT_W-1:0]  n_abv_r,   n_abv_nx_s;
    logic              above_s;

    // State, threshold, run counter and output count registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            thresh_r  <= {DATA_W{1'b0}};
            run_cnt_r <= {RC_W{1'b0}};
            n_abv_r   <= {CNT_W{1'b0}};
        end else begin
            state_r   <= state_nx_s;
            thresh_r  <= thresh_nx_s;
            run_cnt_r <= run_cnt_nx_s;
            n_abv_r   <= n_abv_nx_s;
        end
    end

    // Next-state logic; a capture strobe overrides whatever the FSM is doing
    always_comb begin
        state_nx_s   = state_r;
        thresh_nx_s  = thresh_r;
        run_cnt_nx_s = run_cnt_r;
        n_abv_nx_s   = n_abv_r;
        above_s      = (sig > thresh_r);

        if (strtCapCmp) begin
            thresh_nx_s  = sig;
            run_cnt_nx_s = {RC_W{1'b0}};
            n_abv_nx_s   = {CNT_W{1'b0}};
            state_nx_s   = SEEK;
        end else begin
            case (state_r)
                IDLE: begin
                    run_cnt_nx_s = {RC_W{1'b0}};
                    n_abv_nx_s   = {CNT_W{1'b0}};
                end
                SEEK: begin
                    if (above_s && (run_cnt_r == RUN_LAST)) begin
                        n_abv_nx_s   = (n_abv_r == CNT_MAX) ? CNT_MAX : n_abv_r + CNT_W'(1);
                        run_cnt_nx_s = {RC_W{1'b0}};
                        state_nx_s   = WAIT_LOW;
                    end else if (above_s) begin
                        run_cnt_nx_s = run_cnt_r + RC_W'(1);
                    end else begin
                        run_cnt_nx_s = {RC_W{1'b0}};
                    end
                end
                // Extra above-threshold samples past a counted run are ignored
                WAIT_LOW: begin
                    if (!above_s) begin
                        state_nx_s   = SEEK;
                        run_cnt_nx_s = {RC_W{1'b0}};
                    end else begin
                        state_nx_s   = WAIT_LOW;
                    end
                end
                default: begin
                    state_nx_s   = IDLE;
                    run_cnt_nx_s = {RC_W{1'b0}};
                    n_abv_nx_s   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign N_abv = n_abv_r;

endmodule

// File: tb/tb_run_detect.sv
// Self-checking bench for run_detect: directed scenarios plus random stimulus
// compared against a streak-length reference model.
module tb_run_detect;

    localparam int DATA_W  = 4;
    localparam int RUN_LEN = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst;
    logic              strtCapCmp;
    logic [DATA_W-1:0] sig;
    logic [CNT_W-1:0]  N_abv;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: length of the current above-threshold streak since the
    // last capture or low sample; a run is counted when the streak hits RUN_LEN.
    bit m_armed  = 1'b0;
    int m_thr    = 0;
    int m_streak = 0;
    int m_cnt    = 0;

    run_detect #(
        .DATA_W (DATA_W),
        .RUN_LEN(RUN_LEN),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .strtCapCmp(strtCapCmp),
        .sig       (sig),
        .N_abv     (N_abv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int expected);
        tests_run++;
        assert (N_abv === CNT_W'(expected))
        else begin
            tests_failed++;
            $error("FAIL %s: observed N_abv=%0d expected %0d", tag, N_abv, expected);
        end
    endtask

    // Apply one cycle of stimulus, advance the model, compare after the edge
    task automatic step(input logic r, input logic cap, input int s);
        rst        = r;
        strtCapCmp = cap;
        sig        = DATA_W'(s);
        @(posedge clk);
        if (r) begin
            m_armed = 1'b0; m_thr = 0; m_streak = 0; m_cnt = 0;
        end else if (cap) begin
            m_armed = 1'b1; m_thr = s; m_streak = 0; m_cnt = 0;
        end else if (m_armed) begin
            if (s > m_thr) begin
                m_streak++;
                if (m_streak == RUN_LEN) m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
            end else begin
                m_streak = 0;
            end
        end
        #1;
        check("model", m_cnt);
    endtask

    initial begin
        rst = 1'b1; strtCapCmp = 1'b0; sig = '0;

        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b0, 0);
        check("reset", 0);

        // No capture yet: samples are ignored
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 15);
        check("idle_ignores", 0);

        // Capture threshold 5; broken run
        step(1'b0, 1'b1, 5);
        check("capture", 0);
        step(1'b0, 1'b0, 6); check("broken_6", 0);
        step(1'b0, 1'b0, 8); check("broken_8", 0);
        step(1'b0, 1'b0, 9); check("broken_9", 0);
        step(1'b0, 1'b0, 3); check("broken_3", 0);

        // Qualifying run
        step(1'b0, 1'b0, 6);
        step(1'b0, 1'b0, 8);
        step(1'b0, 1'b0, 9); check("run1_third", 0);
        step(1'b0, 1'b0, 7); check("run1_count", 1);

        // Held high: no re-count
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 7);
        check("hold_high", 1);

        // Sample equal to threshold re-arms
        step(1'b0, 1'b0, 5); check("rearm_equal", 1);
        step(1'b0, 1'b0, 8);
        step(1'b0, 1'b0, 7);
        step(1'b0, 1'b0, 6); check("run2_third", 1);
        step(1'b0, 1'b0, 9); check("run2_count", 2);

        // Fifth above sample, then re-arm clears the run counter
        step(1'b0, 1'b0, 9); check("fifth_above", 2);
        step(1'b0, 1'b0, 2);
        step(1'b0, 1'b0, 6);
        step(1'b0, 1'b0, 6);
        step(1'b0, 1'b0, 9); check("run3_third", 2);
        step(1'b0, 1'b0, 11); check("run3_count", 3);
        step(1'b0, 1'b0, 10); check("run3_after", 3);

        // Mid-run recapture with threshold 8
        step(1'b0, 1'b0, 1);
        step(1'b0, 1'b0, 6);
        step(1'b0, 1'b0, 6);
        step(1'b0, 1'b1, 8); check("recapture", 0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8);
        check("equal_not_above", 0);

        // Reset mid-run returns to idle
        step(1'b0, 1'b0, 9);
        step(1'b0, 1'b0, 9);
        step(1'b1, 1'b0, 9); check("reset_midrun", 0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 9);
        check("idle_after_reset", 0);

        // Saturation with threshold 0
        step(1'b0, 1'b1, 0);
        for (int r = 0; r < 20; r++) begin
            for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1);
            step(1'b0, 1'b0, 0);
        end
        check("saturate", CNT_MAX);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 200) == 0, ($urandom % 24) == 0, int'($urandom % 16));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
